// File: rtl/anc_pkg.sv
// Shared types and constants for the ANC FIR sequencer.
package anc_pkg;

  localparam int QW          = 16;
  localparam int TIMEOUT_DEF = 320;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FROZEN = 2'd3
  } state_t;

  typedef struct packed {
    logic [QW-1:0] x;
    logic [QW-1:0] a;
    logic [QW-1:0] err;
  } sample_t;

endpackage

// File: rtl/sat_neg_shift.sv
// LMS step scaling: dout = sat16(-(din >>> shift)), purely combinational.
// The negation is one bit wider so that -(-32768) clamps to +32767.
module sat_neg_shift
  import anc_pkg::*;
(
  input  logic signed [QW-1:0] din,
  input  logic        [3:0]    shift,
  output logic signed [QW-1:0] dout
);

  logic signed [QW-1:0] shifted;
  logic signed [QW:0]   neg;

  always_comb begin
    shifted = din >>> shift;
    neg     = -{shifted[QW-1], shifted};
    if (neg[QW] != neg[QW-1]) begin
      dout = neg[QW] ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
    end else begin
      dout = neg[QW-1:0];
    end
  end

endmodule

// File: rtl/anc_fir_sequencer.sv
// Launches one FIR run per buffered sample, watches for completion with a watchdog,
// and parks the FIR in scan freeze only between runs.
module anc_fir_sequencer
  import anc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 sample_valid,
  input  logic signed [QW-1:0] x_sample,
  input  logic signed [QW-1:0] a_sample,
  input  logic signed [QW-1:0] err_sample,
  input  logic        [3:0]    mu_shift,
  input  logic                 freeze_req,
  input  logic                 clr_err,
  output logic                 fir_go,
  output logic signed [QW-1:0] x_in,
  output logic signed [QW-1:0] a_in,
  output logic signed [QW-1:0] weight_adjust,
  input  logic                 fir_done,
  input  logic                 fir_out_valid,
  input  logic signed [QW-1:0] fir_out_sample,
  output logic                 scan_freeze,
  output logic signed [QW-1:0] y_out,
  output logic                 y_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout_err,
  output logic        [15:0]   sample_cnt
);

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  state_t              state, state_next;
  sample_t             pend;
  logic                pend_full;
  logic [TW-1:0]       wdog;
  logic                wd_expired;
  logic                consume;
  logic                run_done;
  logic                run_abort;
  logic                sample_drop;
  logic signed [QW-1:0] w_next;

  assign wd_expired  = (wdog == WD_LAST);
  // A sample is only lost when the slot is full and not being emptied this cycle.
  assign sample_drop = sample_valid && pend_full && !consume;

  sat_neg_shift u_sat_neg_shift (
    .din   (pend.err),
    .shift (mu_shift),
    .dout  (w_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (freeze_req) begin
          state_next = ST_FROZEN;
        end else if (enable && pend_full) begin
          state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_next = ST_WAIT;
      ST_WAIT: begin
        if (fir_done || wd_expired) begin
          state_next = ST_IDLE;
        end
      end
      ST_FROZEN: begin
        if (!freeze_req) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    fir_go    = 1'b0;
    busy      = 1'b1;
    consume   = 1'b0;
    run_done  = 1'b0;
    run_abort = 1'b0;
    case (state)
      ST_IDLE: begin
        busy    = 1'b0;
        consume = !freeze_req && enable && pend_full;
      end
      ST_LAUNCH: fir_go = 1'b1;
      ST_WAIT: begin
        run_done  = fir_done;
        run_abort = !fir_done && wd_expired;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      pend_full <= 1'b0;
    end else if (sample_valid && !sample_drop) begin
      pend      <= {x_sample, a_sample, err_sample};
      pend_full <= 1'b1;
    end else if (consume) begin
      pend_full <= 1'b0;
    end
  end

  // Operands are only written on consume, so they hold through LAUNCH and WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_in          <= '0;
      a_in          <= '0;
      weight_adjust <= '0;
    end else if (consume) begin
      x_in          <= pend.x;
      a_in          <= pend.a;
      weight_adjust <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog <= '0;
    end else if (state == ST_LAUNCH) begin
      wdog <= '0;
    end else if (state == ST_WAIT && !fir_done) begin
      wdog <= wdog + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_out      <= '0;
      y_valid    <= 1'b0;
      sample_cnt <= '0;
    end else begin
      y_valid <= run_done && fir_out_valid;
      if (run_done && fir_out_valid) begin
        y_out <= fir_out_sample;
      end
      if (run_done) begin
        sample_cnt <= sample_cnt + 16'd1;
      end
    end
  end

  // Gating with freeze_req lets the release take effect on the same edge as the exit to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_freeze <= 1'b0;
    end else begin
      scan_freeze <= (state == ST_FROZEN) && freeze_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (sample_drop) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
      if (run_abort) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_anc_fir_sequencer.sv
// Scoreboard bench for anc_fir_sequencer: stimulus plus FIR responder on one side,
// a negedge monitor popping expected launches and results on the other.
module tb_anc_fir_sequencer;
  import anc_pkg::*;

  localparam int TO = 320;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] x_sample = '0, a_sample = '0, err_sample = '0;
  logic [3:0]  mu_shift = '0;
  logic        freeze_req = 1'b0, clr_err = 1'b0;
  logic        fir_go;
  logic [15:0] x_in, a_in, weight_adjust;
  logic        fir_done = 1'b0, fir_out_valid = 1'b0;
  logic [15:0] fir_out_sample = '0;
  logic        scan_freeze;
  logic [15:0] y_out;
  logic        y_valid, busy, overrun, timeout_err;
  logic [15:0] sample_cnt;

  anc_fir_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .x_sample(x_sample), .a_sample(a_sample), .err_sample(err_sample),
    .mu_shift(mu_shift), .freeze_req(freeze_req), .clr_err(clr_err),
    .fir_go(fir_go), .x_in(x_in), .a_in(a_in), .weight_adjust(weight_adjust),
    .fir_done(fir_done), .fir_out_valid(fir_out_valid), .fir_out_sample(fir_out_sample),
    .scan_freeze(scan_freeze), .y_out(y_out), .y_valid(y_valid), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] x; logic [15:0] a; logic [15:0] w; } op_t;
  typedef struct { logic [15:0] y; logic [15:0] cnt; } res_t;

  op_t  launch_q[$];
  op_t  run_q[$];
  res_t y_q[$];
  int   checks = 0;
  int   failures = 0;
  int   outstanding = 0;
  int   cur_mu = 0;
  bit   m_overrun = 1'b0;
  logic [15:0] cnt_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: arithmetic shift as floor division, negate, clamp to Q1.15.
  function automatic logic [15:0] ref_w(input logic [15:0] err, input int mu);
    int v, d, q;
    v = int'($signed(err));
    d = 1 << mu;
    if (v >= 0) q = v / d;
    else        q = -((-v + d - 1) / d);
    q = -q;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  function automatic logic [15:0] fir_f(input op_t o);
    return 16'(o.x + o.a - o.w);
  endfunction

  // One-cycle strobe; the model decides accept/drop from its own slot occupancy.
  task automatic offer(input logic [15:0] x, input logic [15:0] a, input logic [15:0] e,
                       input bit inflight, input bit coincide);
    op_t o;
    if (!coincide && (outstanding - (inflight ? 1 : 0)) >= 1) begin
      m_overrun = 1'b1;
    end else begin
      o = '{x, a, ref_w(e, cur_mu)};
      launch_q.push_back(o);
      run_q.push_back(o);
      outstanding++;
    end
    sample_valid = 1'b1; x_sample = x; a_sample = a; err_sample = e;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_go(output bit ok);
    ok = fir_go;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = fir_go;
    end
    chk("fir_go_seen", 32'(ok), 1);
  endtask

  task automatic finish_run(input op_t cur, input bit vld);
    fir_done = 1'b1; fir_out_valid = vld; fir_out_sample = fir_f(cur);
    cnt_m = cnt_m + 16'd1;
    if (vld) y_q.push_back('{fir_f(cur), cnt_m});
    outstanding--;
    @(negedge clk);
    fir_done = 1'b0; fir_out_valid = 1'b0;
  endtask

  task automatic serve(input int dly, input bit vld, input int extra);
    bit  ok;
    op_t cur;
    wait_go(ok);
    if (!ok || run_q.size() == 0) begin
      outstanding = 0;
      return;
    end
    cur = run_q.pop_front();
    for (int k = 0; k < extra; k++) offer(16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
    repeat (dly - extra) @(negedge clk);
    chk("hold_x", 32'(x_in), 32'(cur.x));
    chk("hold_a", 32'(a_in), 32'(cur.a));
    chk("hold_w", 32'(weight_adjust), 32'(cur.w));
    finish_run(cur, vld);
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_overrun = 1'b0;
    chk("clr_overrun", 32'(overrun), 0);
    chk("clr_timeout", 32'(timeout_err), 0);
  endtask

  op_t  mop;
  res_t mres;
  always @(negedge clk) begin
    if (rst_n && fir_go) begin
      chk("go_expected", 32'(launch_q.size() != 0), 1);
      if (launch_q.size() != 0) begin
        mop = launch_q.pop_front();
        chk("go_x_in", 32'(x_in), 32'(mop.x));
        chk("go_a_in", 32'(a_in), 32'(mop.a));
        chk("go_weight", 32'(weight_adjust), 32'(mop.w));
      end
    end
    if (rst_n && y_valid) begin
      chk("y_expected", 32'(y_q.size() != 0), 1);
      if (y_q.size() != 0) begin
        mres = y_q.pop_front();
        chk("y_out", 32'(y_out), 32'(mres.y));
        chk("y_cnt", 32'(sample_cnt), 32'(mres.cnt));
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "global timeout");
  end

  initial begin
    bit  ok;
    op_t cur;
    int  gos, ys;

    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_flags", 32'({fir_go, scan_freeze, y_valid, busy, overrun, timeout_err}), 0);
    chk("rst_ops", 32'(x_in | a_in | weight_adjust), 0);
    chk("rst_y_cnt", 32'({y_out, sample_cnt}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gos = 0;
    repeat (5) begin @(negedge clk); gos += int'(fir_go); end
    chk("no_go_after_reset", 32'(gos), 0);

    // Nominal run: go exactly two cycles after the strobe, done 263 cycles later.
    cur_mu = 2; mu_shift = 4'd2;
    offer(16'h1000, 16'h0200, 16'h4000, 1'b0, 1'b0);
    @(negedge clk);
    chk("nominal_go_latency", 32'(fir_go), 1);
    chk("nominal_weight", 32'(weight_adjust), 32'h0000F000);
    serve(263, 1'b1, 0);
    chk("nominal_cnt", 32'(sample_cnt), 1);

    // Saturation corner.
    cur_mu = 0; mu_shift = 4'd0;
    offer(16'h7FFF, 16'h8000, 16'h8000, 1'b0, 1'b0);
    @(negedge clk);
    chk("sat_weight", 32'(weight_adjust), 32'h00007FFF);
    serve(5, 1'b1, 0);

    // A strobe landing on the consume cycle is kept without an overrun.
    cur_mu = 3; mu_shift = 4'd3;
    offer(16'h0011, 16'h0022, 16'hF000, 1'b0, 1'b0);
    offer(16'h0033, 16'h0044, 16'h0FF0, 1'b0, 1'b1);
    chk("coincide_no_overrun", 32'(overrun), 32'(m_overrun));
    while (outstanding > 0) serve(7, 1'b1, 0);

    // Overrun: first strobe runs, second waits, third is dropped.
    cur_mu = 1; mu_shift = 4'd1;
    offer(16'h0101, 16'h0202, 16'h0303, 1'b0, 1'b0);
    serve(30, 1'b1, 2);
    while (outstanding > 0) serve(9, 1'b1, 0);
    chk("overrun_set", 32'(overrun), 32'(m_overrun));
    chk("overrun_expected", 32'(m_overrun), 1);
    clear_errs();

    // enable low holds off new launches only.
    enable = 1'b0;
    offer(16'h0AAA, 16'h0BBB, 16'h0CCC, 1'b0, 1'b0);
    gos = 0;
    repeat (10) begin @(negedge clk); gos += int'(fir_go); end
    chk("enable_low_no_go", 32'(gos), 0);
    enable = 1'b1;
    serve(12, 1'b0, 0);

    // Freeze requested mid-run takes effect only after done.
    offer(16'h0123, 16'h0456, 16'h0789, 1'b0, 1'b0);
    wait_go(ok);
    cur = run_q.pop_front();
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 5) freeze_req = 1'b1;
      if (i > 5) chk("freeze_held_off", 32'(scan_freeze), 0);
    end
    finish_run(cur, 1'b1);
    ok = scan_freeze;
    for (int i = 0; i < 8 && !ok; i++) begin @(negedge clk); ok = scan_freeze; end
    chk("freeze_rise", 32'(ok), 1);
    offer(16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("frozen_no_go", 32'({fir_go, scan_freeze}), 1);
    end
    freeze_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin @(negedge clk); ok = !scan_freeze; end
    chk("freeze_fall", 32'(ok), 1);
    @(negedge clk);
    chk("unfreeze_go", 32'(fir_go), 1);
    serve(10, 1'b1, 0);

    // Watchdog abort with no done; a late done must be ignored.
    offer(16'h4444, 16'h5555, 16'h6666, 1'b0, 1'b0);
    wait_go(ok);
    cur = run_q.pop_front();
    repeat (TO - 1) @(negedge clk);
    chk("timeout_early", 32'(timeout_err), 0);
    repeat (2) @(negedge clk);
    chk("timeout_set", 32'(timeout_err), 1);
    chk("timeout_idle", 32'(busy), 0);
    outstanding--;
    fir_done = 1'b1; fir_out_valid = 1'b1; fir_out_sample = 16'h1234;
    @(negedge clk);
    fir_done = 1'b0; fir_out_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_done_cnt", 32'(sample_cnt), 32'(cnt_m));
    clear_errs();

    // Randomized runs.
    for (int it = 0; it < 20; it++) begin
      cur_mu = int'($urandom_range(0, 15));
      mu_shift = 4'(cur_mu);
      offer(16'($urandom), 16'($urandom), (it % 5 == 0) ? 16'h8000 : 16'($urandom), 1'b0, 1'b0);
      serve(int'($urandom_range(3, 60)), 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)));
      while (outstanding > 0) serve(int'($urandom_range(1, 40)), 1'($urandom_range(0, 3) != 0), 0);
      chk("rand_overrun", 32'(overrun), 32'(m_overrun));
      chk("rand_cnt", 32'(sample_cnt), 32'(cnt_m));
      if (m_overrun) clear_errs();
    end

    // Reset 100 cycles into a run.
    offer(16'h7777, 16'h0808, 16'h0909, 1'b0, 1'b0);
    wait_go(ok);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("midrst_flags", 32'({fir_go, scan_freeze, y_valid, busy, overrun, timeout_err}), 0);
    chk("midrst_ops", 32'(x_in | a_in | weight_adjust), 0);
    chk("midrst_y_cnt", 32'({y_out, sample_cnt}), 0);
    launch_q.delete(); run_q.delete(); y_q.delete();
    outstanding = 0; cnt_m = '0; m_overrun = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fir_done = 1'b1; fir_out_valid = 1'b1; fir_out_sample = 16'h5A5A;
    @(negedge clk);
    fir_done = 1'b0; fir_out_valid = 1'b0;
    gos = 0; ys = 0;
    repeat (10) begin @(negedge clk); gos += int'(fir_go); ys += int'(y_valid); end
    chk("midrst_no_go", 32'(gos), 0);
    chk("midrst_no_y", 32'(ys), 0);
    chk("midrst_idle", 32'({busy, sample_cnt}), 0);

    chk("launch_q_drained", 32'(launch_q.size()), 0);
    chk("y_q_drained", 32'(y_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
